lu_rr_arbiter: RTL and testbench

//  Shares one 2-input logical unit (logicalunit: out = func[{a,b}]) between N requesters.

---
 rtl/lu_pkg.sv | 11 +
 rtl/lu_rr_arbiter_if.sv | 19 +
 rtl/logicalunit.sv | 9 +
 rtl/lu_rr_arbiter.sv | 58 +++++
 tb/tb_lu_rr_arbiter.sv | 122 ++++++++++++
 5 files changed

// File: rtl/lu_pkg.sv
// lu_pkg: shared constants, truth tables and id-width helper for the logic-unit arbiter
package lu_pkg;
  localparam int N_DEF = 4;
  localparam logic [3:0] LU_AND  = 4'b1000;
  localparam logic [3:0] LU_OR   = 4'b1110;
  localparam logic [3:0] LU_XOR  = 4'b0110;
  localparam logic [3:0] LU_NAND = 4'b0111;
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/lu_rr_arbiter_if.sv
// lu_rr_arbiter_if: requester-side and result-side signals of the shared logic-unit arbiter
interface lu_rr_arbiter_if
  import lu_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDW = id_width(N)
);
  logic [N-1:0] req;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [4*N-1:0] func;
  logic [N-1:0] gnt;
  logic out_valid;
  logic out_data;
  logic [IDW-1:0] out_id;
  logic out_ready;
  modport master (output req, a, b, func, out_ready, input gnt, out_valid, out_data, out_id);
  modport slave (input req, a, b, func, out_ready, output gnt, out_valid, out_data, out_id);
endinterface

// File: rtl/logicalunit.sv
// logicalunit: two-input logic function selected by a 4-bit truth table, a is the selector MSB
module logicalunit (
  input  logic a,
  input  logic b,
  input  logic [3:0] func,
  output logic out
);
  assign out = func[{a, b}];
endmodule

// File: rtl/lu_rr_arbiter.sv
// lu_rr_arbiter: round-robin sharing of one logic unit among N requesters with a registered result
module lu_rr_arbiter
  import lu_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDW = id_width(N)
) (
  input logic clk,
  input logic rst_n,
  lu_rr_arbiter_if.slave bus
);
  logic [IDW-1:0] ptr, idx, off, id_q;
  logic [IDW:0] sum;
  logic [N-1:0] rot;
  logic hit, free, xfer, res, valid_q, data_q;
  assign free = !valid_q | bus.out_ready;
  // rotate req so ptr sits at bit 0, then take the lowest set bit and map it back to an index
  always_comb begin
    rot = N'({bus.req, bus.req} >> ptr);
    hit = 1'b0;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        off = IDW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = IDW'((int'(sum) >= N) ? int'(sum) - N : int'(sum));
  end
  assign xfer = hit & free & rst_n;
  assign bus.gnt = xfer ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  logicalunit u_lu (
    .a(bus.a[idx]),
    .b(bus.b[idx]),
    .func(bus.func[{idx, 2'b00} +: 4]),
    .out(res)
  );
  // result register: load on transfer, drop valid when accepted without a replacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= 1'b0;
      id_q <= '0;
      ptr <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q <= res;
      id_q <= idx;
      ptr <= (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_id = id_q;
endmodule

// File: tb/tb_lu_rr_arbiter.sv
// tb_lu_rr_arbiter: directed grant checks with a scoreboard of expected results
module tb_lu_rr_arbiter;
  import lu_pkg::*;
  typedef struct {
    logic [1:0] id;
    logic d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lu_rr_arbiter_if #(.N(4)) bus ();
  lu_rr_arbiter #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;
  logic mv = 1'b0;
  logic md = 1'b0;
  logic [1:0] mi = 2'd0;
  logic [3:0] fv[4];
  logic [3:0] av, bv;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic set_op(input int i, input logic ai, input logic bi, input logic [3:0] f);
    av[i] = ai;
    bv[i] = bi;
    fv[i] = f;
    bus.a = av;
    bus.b = bv;
    bus.func = {fv[3], fv[2], fv[1], fv[0]};
  endtask
  task automatic step(input string tag, input logic [3:0] r, input logic rdy, input logic [3:0] eg);
    exp_t e;
    logic [3:0] f;
    bus.req = r;
    bus.out_ready = rdy;
    #1;
    check({tag, " gnt"}, 32'(bus.gnt), 32'(eg));
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        f = fv[i];
        e.id = 2'(i);
        e.d = f[{av[i], bv[i]}];
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      mv = 1'b1;
      md = e.d;
      mi = e.id;
    end else if (rdy) begin
      mv = 1'b0;
    end
    check({tag, " valid"}, 32'(bus.out_valid), 32'(mv));
    check({tag, " id"}, 32'(bus.out_id), 32'(mi));
    check({tag, " data"}, 32'(bus.out_data), 32'(md));
    @(negedge clk);
  endtask
  initial begin
    bus.req = 4'b1111;
    bus.out_ready = 1'b0;
    av = '0;
    bv = '0;
    for (int i = 0; i < 4; i++) set_op(i, 1'b0, 1'b0, LU_OR);
    #2;
    check("rst gnt", 32'(bus.gnt), 32'd0);
    check("rst valid", 32'(bus.out_valid), 32'd0);
    check("rst data", 32'(bus.out_data), 32'd0);
    check("rst id", 32'(bus.out_id), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("t1 first", 4'b1111, 1'b1, 4'b0001);
    set_op(2, 1'b1, 1'b0, LU_XOR);
    step("t2 single", 4'b0100, 1'b1, 4'b0100);
    check("t2 data const", 32'(bus.out_data), 32'd1);
    check("t2 id const", 32'(bus.out_id), 32'd2);
    for (int i = 0; i < 4; i++) set_op(i, 1'b1, 1'b1, LU_AND);
    step("t3 align", 4'b1000, 1'b1, 4'b1000);
    step("t3 rr0", 4'b1111, 1'b1, 4'b0001);
    step("t3 rr1", 4'b1111, 1'b1, 4'b0010);
    step("t3 rr2", 4'b1111, 1'b1, 4'b0100);
    step("t3 rr3", 4'b1111, 1'b1, 4'b1000);
    step("t3 rr4", 4'b1111, 1'b1, 4'b0001);
    step("t3 rr5", 4'b1111, 1'b1, 4'b0010);
    set_op(2, 1'b0, 1'b1, LU_NAND);
    for (int i = 0; i < 3; i++) step("t4 stall", 4'b1111, 1'b0, 4'b0000);
    step("t4 resume2", 4'b1111, 1'b1, 4'b0100);
    step("t4 resume3", 4'b1111, 1'b1, 4'b1000);
    set_op(1, 1'b0, 1'b0, LU_NAND);
    step("t5 g1", 4'b0010, 1'b1, 4'b0010);
    for (int i = 0; i < 5; i++) step("t5 idle", 4'b0000, 1'b1, 4'b0000);
    step("t5 wrap", 4'b0011, 1'b1, 4'b0001);
    step("t5 next", 4'b0011, 1'b1, 4'b0010);
    step("t6 load", 4'b0001, 1'b1, 4'b0001);
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async valid", 32'(bus.out_valid), 32'd0);
    check("t6 async id", 32'(bus.out_id), 32'd0);
    check("t6 async data", 32'(bus.out_data), 32'd0);
    check("t6 async gnt", 32'(bus.gnt), 32'd0);
    #1;
    rst_n = 1'b1;
    mv = 1'b0;
    md = 1'b0;
    mi = 2'd0;
    @(negedge clk);
    set_op(3, 1'b1, 1'b0, LU_OR);
    step("t6 after", 4'b1000, 1'b1, 4'b1000);
    step("t6 drain", 4'b0000, 1'b1, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
